// File: rtl/spi_flash_engine.sv
// Single-lane SPI mode-0 flash transaction engine: write words, optional dummy words, then read words.
// One bus word costs 1 load tick + 2*DSIZE shift ticks; wr_vld gaps and rd_ready backpressure stall SCLK with CS held low.
`timescale 1ns/1ps
module spi_flash_engine #(
  parameter int DSIZE       = 8,
  parameter int CSIZE       = 3,
  parameter int DUMMY_BYTES = 1
) (
  input  logic             clock,
  input  logic             clk_en,
  input  logic             rst,
  input  logic             request,
  input  logic [CSIZE-1:0] req_cmd,
  input  logic [23:0]      req_len,
  input  logic [23:0]      req_wr_len,
  output logic             busy,
  output logic             finish,
  input  logic             wr_vld,
  input  logic [DSIZE-1:0] wr_data,
  output logic             wr_ready,
  input  logic             wr_last,
  input  logic             rd_ready,
  output logic             rd_vld,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_last,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int BW  = $clog2(2 * DSIZE);
  localparam int DMW = (DUMMY_BYTES < 1) ? 1 : $clog2(DUMMY_BYTES + 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(2 * DSIZE - 1);
  localparam logic [DMW-1:0] DUMMY_CNT = DMW'(DUMMY_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    SHIFT,
    PUSH,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  logic [23:0]      wr_rem;
  logic [23:0]      rd_rem;
  logic [DMW-1:0]   dm_rem;
  logic [BW-1:0]    bit_cnt;
  logic [DSIZE-1:0] shreg;
  logic             cur_rd;

  logic [23:0] wr_min;
  logic        more_words;
  logic        unused_inputs;

  assign wr_min        = (req_wr_len < req_len) ? req_wr_len : req_len;
  assign more_words    = (wr_rem != '0) || (dm_rem != '0) || (rd_rem != '0);
  assign unused_inputs = ^{wr_last, req_cmd[CSIZE-1:1]};

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      finish   <= 1'b0;
      wr_ready <= 1'b0;
      rd_vld   <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      wr_rem   <= '0;
      rd_rem   <= '0;
      dm_rem   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cur_rd   <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          finish <= 1'b0;
          if (request) begin
            busy   <= 1'b1;
            wr_rem <= wr_min;
            rd_rem <= req_len - wr_min;
            dm_rem <= req_cmd[0] ? DUMMY_CNT : '0;
            state  <= (req_len == '0) ? DONE : SETUP;
          end
        end
        SETUP: begin
          spi_cs_n <= 1'b0;
          wr_ready <= (wr_rem != '0);
          state    <= LOAD;
        end
        LOAD: begin
          if (wr_rem != '0) begin
            if (wr_vld && wr_ready) begin
              shreg    <= wr_data;
              spi_mosi <= wr_data[DSIZE-1];
              wr_ready <= 1'b0;
              wr_rem   <= wr_rem - 24'd1;
              cur_rd   <= 1'b0;
              bit_cnt  <= '0;
              state    <= SHIFT;
            end
          end else begin
            // dummy and read words drive MOSI low for the whole word
            shreg    <= '0;
            spi_mosi <= 1'b0;
            bit_cnt  <= '0;
            state    <= SHIFT;
            if (dm_rem != '0) begin
              dm_rem <= dm_rem - DMW'(1);
              cur_rd <= 1'b0;
            end else begin
              rd_rem <= rd_rem - 24'd1;
              cur_rd <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + BW'(1);
          if (!bit_cnt[0]) begin
            spi_sclk <= 1'b1;
            shreg    <= {shreg[DSIZE-2:0], spi_miso};
          end else begin
            spi_sclk <= 1'b0;
            if (bit_cnt != BIT_LAST) begin
              spi_mosi <= shreg[DSIZE-1];
            end else if (cur_rd) begin
              rd_vld  <= 1'b1;
              rd_data <= shreg;
              rd_last <= (rd_rem == '0);
              state   <= PUSH;
            end else if (more_words) begin
              wr_ready <= (wr_rem != '0);
              state    <= LOAD;
            end else begin
              state <= HOLD;
            end
          end
        end
        PUSH: begin
          if (rd_ready) begin
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
            state   <= (rd_rem != '0) ? LOAD : HOLD;
          end
        end
        HOLD: begin
          spi_cs_n <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy   <= 1'b0;
          finish <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
